// File: rtl/ac97_pkg.sv
// Shared AC-link constants, bus payload types and register reset values.
package ac97_pkg;

  localparam int unsigned SLOT_W   = 20;
  localparam int unsigned REG_W    = 16;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_REGS = 64;

  localparam logic [CNT_W-1:0] SLOT0_END = 8'd15;
  localparam logic [CNT_W-1:0] SLOT1_END = 8'd35;
  localparam logic [CNT_W-1:0] SLOT2_END = 8'd55;
  localparam logic [CNT_W-1:0] SLOT3_END = 8'd75;
  localparam logic [CNT_W-1:0] SLOT4_END = 8'd95;

  localparam logic [6:0] REG_RESET = 7'h00;
  localparam logic [6:0] REG_PWRDN = 7'h26;
  localparam logic [6:0] REG_VID1  = 7'h7C;
  localparam logic [6:0] REG_VID2  = 7'h7E;

  typedef struct packed {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [REG_W-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [REG_W-1:0] data;
  } status_t;

  // Power-on contents of one even register, indexed by register/2.
  function automatic logic [REG_W-1:0] reg_reset_val(input logic [IDX_W-1:0] idx,
                                                     input logic [REG_W-1:0] vid1,
                                                     input logic [REG_W-1:0] vid2);
    logic [REG_W-1:0] val;
    val = '0;
    case ({idx, 1'b0})
      REG_PWRDN: val = 16'h000F;
      REG_VID1:  val = vid1;
      REG_VID2:  val = vid2;
      default:   val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ac97_regfile.sv
// 64x16 mixer register file: masked writes, full restore on a write to 0x00.
module ac97_regfile
  import ac97_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID1 = 16'h4144,
  parameter logic [15:0] VENDOR_ID2 = 16'h5370
) (
  input  logic             clk,
  input  logic             rst,
  input  wr_req_t          wr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [REG_W-1:0] rd_data,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [REG_W-1:0] dbg_data
);

  logic [REG_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= reg_reset_val(IDX_W'(i), VENDOR_ID1, VENDOR_ID2);
      end
    end else if (wr.we) begin
      case ({wr.idx, 1'b0})
        REG_RESET: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= reg_reset_val(IDX_W'(i), VENDOR_ID1, VENDOR_ID2);
          end
        end
        REG_VID1, REG_VID2: begin
        end
        // Only the power-down control byte is writable; status nibble reads ready.
        REG_PWRDN: mem[wr.idx] <= {wr.data[15:8], 8'h0F};
        default:   mem[wr.idx] <= wr.data;
      endcase
    end
  end

  assign rd_data  = mem[rd_idx];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/ac97_codec_link.sv
// Codec side of the AC-link: deframes controller frames, serves register
// commands and playback, and serializes status and capture frames.
module ac97_codec_link
  import ac97_pkg::*;
#(
  parameter int unsigned READY_FRAMES = 4,
  parameter logic [15:0] VENDOR_ID1   = 16'h4144,
  parameter logic [15:0] VENDOR_ID2   = 16'h5370
) (
  input  logic              ac97_bit_clock,
  input  logic              reset,
  input  logic              ac97_synch,
  input  logic              ac97_sdata_out,
  output logic              ac97_sdata_in,
  input  logic [SLOT_W-1:0] cap_left,
  input  logic [SLOT_W-1:0] cap_right,
  output logic [SLOT_W-1:0] play_left,
  output logic [SLOT_W-1:0] play_right,
  output logic              play_strobe,
  output logic              codec_ready,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [REG_W-1:0]  dbg_data,
  output logic              frame_err
);

  logic              sync_q;
  logic              locked;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  rdy_cnt;
  logic [SLOT_W-1:0] rx_sh;
  logic [4:0]        tag_q;
  logic [6:0]        cmd_q;
  logic [SLOT_W-1:0] left_hold;
  status_t           pending;
  status_t           tx_stat;
  logic [SLOT_W-1:0] tx_capl;
  logic [SLOT_W-1:0] tx_capr;
  wr_req_t           wr;
  logic [REG_W-1:0]  rd_data;

  logic              sync_rise;
  logic              frame_start;
  logic              ready_now;
  logic [CNT_W-1:0]  rx_idx;
  logic [SLOT_W-1:0] rx_word;
  logic [15:0]       tag_word;
  logic [SLOT_W-1:0] slot1_word;
  logic [SLOT_W-1:0] slot2_word;
  logic              tx_bit;

  // A missing sync lets the counter wrap to 0, which starts a frame on its own.
  assign sync_rise   = ac97_synch & ~sync_q;
  assign frame_start = sync_rise | (locked & (bit_cnt == '0));
  assign ready_now   = (rdy_cnt >= CNT_W'(READY_FRAMES));
  assign rx_idx      = bit_cnt - 8'd1;
  assign rx_word     = {rx_sh[SLOT_W-2:0], ac97_sdata_out};

  assign tag_word   = {codec_ready, tx_stat.valid, tx_stat.valid, codec_ready, codec_ready, 11'h0};
  assign slot1_word = {1'b0, tx_stat.idx, 1'b0, 12'h0};
  assign slot2_word = {tx_stat.data, 4'h0};

  // Outgoing bit for frame position bit_cnt (1..255); position 0 is launched at frame start.
  always_comb begin
    tx_bit = 1'b0;
    if (bit_cnt <= SLOT0_END)      tx_bit = tag_word[4'(SLOT0_END - bit_cnt)];
    else if (bit_cnt <= SLOT1_END) tx_bit = slot1_word[5'(SLOT1_END - bit_cnt)];
    else if (bit_cnt <= SLOT2_END) tx_bit = slot2_word[5'(SLOT2_END - bit_cnt)];
    else if (bit_cnt <= SLOT3_END) tx_bit = tx_capl[5'(SLOT3_END - bit_cnt)];
    else if (bit_cnt <= SLOT4_END) tx_bit = tx_capr[5'(SLOT4_END - bit_cnt)];
  end

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      sync_q        <= 1'b0;
      locked        <= 1'b0;
      bit_cnt       <= '0;
      rdy_cnt       <= '0;
      rx_sh         <= '0;
      tag_q         <= '0;
      cmd_q         <= '0;
      left_hold     <= '0;
      pending       <= '0;
      tx_stat       <= '0;
      tx_capl       <= '0;
      tx_capr       <= '0;
      wr            <= '0;
      ac97_sdata_in <= 1'b0;
      play_left     <= '0;
      play_right    <= '0;
      play_strobe   <= 1'b0;
      codec_ready   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sync_q      <= ac97_synch;
      play_strobe <= 1'b0;
      frame_err   <= 1'b0;
      wr          <= '0;
      if (frame_start) begin
        bit_cnt       <= 8'd1;
        locked        <= 1'b1;
        frame_err     <= sync_rise & (bit_cnt != '0);
        ac97_sdata_in <= ready_now;
        codec_ready   <= ready_now;
        if (!ready_now) rdy_cnt <= rdy_cnt + 8'd1;
        tx_stat       <= pending;
        pending       <= '0;
        tx_capl       <= ready_now ? cap_left  : '0;
        tx_capr       <= ready_now ? cap_right : '0;
      end else if (locked) begin
        bit_cnt       <= bit_cnt + 8'd1;
        ac97_sdata_in <= tx_bit;
        rx_sh         <= rx_word;
        case (rx_idx)
          SLOT0_END: tag_q <= rx_word[15:11];
          SLOT1_END: cmd_q <= rx_word[19:13];
          SLOT2_END: begin
            // One command per frame, honoured only with valid, slot1 and slot2 tags.
            if (&tag_q[4:2]) begin
              if (cmd_q[6]) begin
                pending.valid <= 1'b1;
                pending.idx   <= cmd_q[5:0];
                pending.data  <= rd_data;
              end else begin
                wr.we   <= 1'b1;
                wr.idx  <= cmd_q[5:0];
                wr.data <= rx_word[19:4];
              end
            end
          end
          SLOT3_END: left_hold <= rx_word;
          SLOT4_END: begin
            if (tag_q[1]) play_left  <= left_hold;
            if (tag_q[0]) play_right <= rx_word;
            play_strobe <= tag_q[1] | tag_q[0];
          end
          default: begin
          end
        endcase
      end
    end
  end

  ac97_regfile #(
    .VENDOR_ID1(VENDOR_ID1),
    .VENDOR_ID2(VENDOR_ID2)
  ) u_regfile (
    .clk     (ac97_bit_clock),
    .rst     (reset),
    .wr      (wr),
    .rd_idx  (cmd_q[5:0]),
    .rd_data (rd_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

endmodule

// File: tb/tb_ac97_codec_link.sv
// Directed bench for ac97_codec_link acting as the AC97 controller.
module tb_ac97_codec_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        ac97_synch;
  logic        ac97_sdata_out;
  logic        ac97_sdata_in;
  logic [19:0] cap_left;
  logic [19:0] cap_right;
  logic [19:0] play_left;
  logic [19:0] play_right;
  logic        play_strobe;
  logic        codec_ready;
  logic [5:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  logic [255:0] rb;
  logic [255:0] ex;
  int           st;
  int           er;

  always #5 clk = ~clk;

  ac97_codec_link dut (
    .ac97_bit_clock(clk),
    .reset         (reset),
    .ac97_synch    (ac97_synch),
    .ac97_sdata_out(ac97_sdata_out),
    .ac97_sdata_in (ac97_sdata_in),
    .cap_left      (cap_left),
    .cap_right     (cap_right),
    .play_left     (play_left),
    .play_right    (play_right),
    .play_strobe   (play_strobe),
    .codec_ready   (codec_ready),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .frame_err     (frame_err)
  );

  // Frame bit i is slot-0 bit 15-i; each slot is sent MSB first.
  function automatic logic [255:0] put_slots(input logic [15:0] t, input logic [19:0] s1,
                                             input logic [19:0] s2, input logic [19:0] s3,
                                             input logic [19:0] s4);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i] = t[15-i];
    for (int j = 0; j < 20; j++) begin
      f[16+j] = s1[19-j];
      f[36+j] = s2[19-j];
      f[56+j] = s3[19-j];
      f[76+j] = s4[19-j];
    end
    return f;
  endfunction

  // Drives nbits bit periods of frame f; returns captured sdata_in bits and pulse counts.
  task automatic send_frame(input logic [255:0] f, input int nbits, output logic [255:0] r,
                            output int strobes, output int errs);
    r = '0;
    strobes = 0;
    errs = 0;
    for (int n = 0; n < nbits; n++) begin
      @(negedge clk);
      if (n >= 1) r[n-1] = ac97_sdata_in;
      if (play_strobe) strobes++;
      if (frame_err) errs++;
      ac97_synch     = (n < 16);
      ac97_sdata_out = (n == 0) ? 1'b0 : f[n-1];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ac97_synch = 1'b0; ac97_sdata_out = 1'b0;
    cap_left = '0; cap_right = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    total++; if ({ac97_sdata_in, play_strobe, codec_ready, frame_err} !== 4'b0) begin bad++; $display("FAIL reset_bits got=%b want=0000", {ac97_sdata_in, play_strobe, codec_ready, frame_err}); end
    total++; if ({play_left, play_right} !== 40'h0) begin bad++; $display("FAIL reset_play got=%h want=0", {play_left, play_right}); end
    dbg_addr = 6'h13; #1;
    total++; if (dbg_data !== 16'h000F) begin bad++; $display("FAIL reset_reg26 got=%h want=000f", dbg_data); end
    dbg_addr = 6'h3E; #1;
    total++; if (dbg_data !== 16'h4144) begin bad++; $display("FAIL reset_reg7c got=%h want=4144", dbg_data); end
    dbg_addr = 6'h3F; #1;
    total++; if (dbg_data !== 16'h5370) begin bad++; $display("FAIL reset_reg7e got=%h want=5370", dbg_data); end
    dbg_addr = 6'h01; #1;
    total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL reset_reg02 got=%h want=0000", dbg_data); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ac97_sdata_in !== 1'b0) begin bad++; $display("FAIL unlocked_sdata got=%b want=0", ac97_sdata_in); end
  endtask

  task automatic test_ready();
    for (int k = 0; k < 4; k++) begin
      send_frame('0, 256, rb, st, er);
      total++; if (rb[254:0] !== 255'h0) begin bad++; $display("FAIL not_ready_frame%0d got=%h want=0", k, rb[254:0]); end
    end
    total++; if (codec_ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b want=0", codec_ready); end
    send_frame('0, 256, rb, st, er);
    ex = put_slots(16'h9800, '0, '0, '0, '0);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL ready_frame got=%h want=%h", rb[254:0], ex[254:0]); end
    total++; if (codec_ready !== 1'b1) begin bad++; $display("FAIL ready_flag got=%b want=1", codec_ready); end
  endtask

  task automatic test_write_read();
    ex = put_slots(16'h9800, '0, '0, '0, '0);
    send_frame(put_slots(16'hE000, 20'h02000, 20'h80000, '0, '0), 256, rb, st, er);
    send_frame(put_slots(16'hE000, 20'h82000, '0, '0, '0), 256, rb, st, er);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL rd_no_early_status got=%h want=%h", rb[254:0], ex[254:0]); end
    send_frame('0, 256, rb, st, er);
    ex = put_slots(16'hF800, 20'h02000, 20'h80000, '0, '0);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL rd_status_02 got=%h want=%h", rb[254:0], ex[254:0]); end
    dbg_addr = 6'h01; #1;
    total++; if (dbg_data !== 16'h8000) begin bad++; $display("FAIL dbg_reg02 got=%h want=8000", dbg_data); end
    send_frame('0, 256, rb, st, er);
    ex = put_slots(16'h9800, '0, '0, '0, '0);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL status_cleared got=%h want=%h", rb[254:0], ex[254:0]); end
  endtask

  task automatic test_vendor();
    send_frame(put_slots(16'hE000, 20'hFC000, '0, '0, '0), 256, rb, st, er);
    send_frame(put_slots(16'hE000, 20'h7C000, 20'h00000, '0, '0), 256, rb, st, er);
    ex = put_slots(16'hF800, 20'h7C000, 20'h41440, '0, '0);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL rd_vid1 got=%h want=%h", rb[254:0], ex[254:0]); end
    send_frame(put_slots(16'hE000, 20'hFC000, '0, '0, '0), 256, rb, st, er);
    send_frame('0, 256, rb, st, er);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL vid1_readonly got=%h want=%h", rb[254:0], ex[254:0]); end
  endtask

  task automatic test_restore();
    send_frame(put_slots(16'hE000, 20'h02000, 20'h12340, '0, '0), 256, rb, st, er);
    dbg_addr = 6'h01; #1;
    total++; if (dbg_data !== 16'h1234) begin bad++; $display("FAIL wr_reg02 got=%h want=1234", dbg_data); end
    send_frame(put_slots(16'hE000, 20'h26000, 20'hABCD0, '0, '0), 256, rb, st, er);
    dbg_addr = 6'h13; #1;
    total++; if (dbg_data !== 16'hAB0F) begin bad++; $display("FAIL wr_reg26_mask got=%h want=ab0f", dbg_data); end
    send_frame(put_slots(16'hE000, 20'h00000, 20'h00000, '0, '0), 256, rb, st, er);
    dbg_addr = 6'h01; #1;
    total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL restore_reg02 got=%h want=0000", dbg_data); end
    dbg_addr = 6'h13; #1;
    total++; if (dbg_data !== 16'h000F) begin bad++; $display("FAIL restore_reg26 got=%h want=000f", dbg_data); end
    dbg_addr = 6'h3F; #1;
    total++; if (dbg_data !== 16'h5370) begin bad++; $display("FAIL restore_reg7e got=%h want=5370", dbg_data); end
  endtask

  task automatic test_playback();
    cap_left = 20'h0F0F0; cap_right = 20'h55AA5;
    send_frame(put_slots(16'h9800, '0, '0, 20'hABCDE, 20'h12345), 256, rb, st, er);
    ex = put_slots(16'h9800, '0, '0, 20'h0F0F0, 20'h55AA5);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL capture_slots got=%h want=%h", rb[254:0], ex[254:0]); end
    total++; if (st !== 1) begin bad++; $display("FAIL strobe_both got=%0d want=1", st); end
    total++; if ({play_left, play_right} !== 40'hABCDE12345) begin bad++; $display("FAIL play_both got=%h want=abcde12345", {play_left, play_right}); end
    send_frame(put_slots(16'h9000, '0, '0, 20'h11111, 20'h22222), 256, rb, st, er);
    total++; if (st !== 1) begin bad++; $display("FAIL strobe_left got=%0d want=1", st); end
    total++; if ({play_left, play_right} !== 40'h1111112345) begin bad++; $display("FAIL play_left_only got=%h want=1111112345", {play_left, play_right}); end
    cap_left = '0; cap_right = '0;
    send_frame(put_slots(16'h8000, '0, '0, 20'h33333, 20'h44444), 256, rb, st, er);
    total++; if (st !== 0) begin bad++; $display("FAIL strobe_none got=%0d want=0", st); end
    total++; if ({play_left, play_right} !== 40'h1111112345) begin bad++; $display("FAIL play_hold got=%h want=1111112345", {play_left, play_right}); end
  endtask

  task automatic test_premature();
    send_frame(put_slots(16'hE000, 20'h02000, 20'h77770, '0, '0), 41, rb, st, er);
    total++; if (er !== 0) begin bad++; $display("FAIL err_before_resync got=%0d want=0", er); end
    send_frame(put_slots(16'hE000, 20'h04000, 20'h5A5A0, '0, '0), 256, rb, st, er);
    total++; if (er !== 1) begin bad++; $display("FAIL frame_err_pulse got=%0d want=1", er); end
    ex = put_slots(16'h9800, '0, '0, '0, '0);
    total++; if (rb[254:0] !== ex[254:0]) begin bad++; $display("FAIL resync_frame got=%h want=%h", rb[254:0], ex[254:0]); end
    dbg_addr = 6'h01; #1;
    total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL partial_write_dropped got=%h want=0000", dbg_data); end
    dbg_addr = 6'h02; #1;
    total++; if (dbg_data !== 16'h5A5A) begin bad++; $display("FAIL resync_write got=%h want=5a5a", dbg_data); end
    send_frame('0, 256, rb, st, er);
    total++; if (er !== 0) begin bad++; $display("FAIL err_after_resync got=%0d want=0", er); end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_write_read();
    test_vendor();
    test_restore();
    test_playback();
    test_premature();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
